// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator constants, the conv1 weight loader state encoding
// and a small helper used by the loader's read-issue logic.
package lenet_pkg;

   localparam int W1_TAPS       = 25;
   localparam int W1_DATA_W     = 48;
   localparam int W1_ADDR_W     = 5;
   localparam int W1_FIFO_DEPTH = 3;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_FETCH = 2'd1,
      LD_DRAIN = 2'd2,
      LD_DONE  = 2'd3
   } w1_ld_state_e;

   // A new ROM read may be issued only if the word it returns is guaranteed
   // a FIFO slot, counting the one still in flight from the previous cycle.
   function automatic logic w1_has_room(input logic [1:0] count,
                                        input logic       inflight);
      return ({1'b0, count} + {2'b00, inflight}) < 3'(W1_FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/w1_skid_fifo.sv
// Small circular FIFO holding {weight word, tap index} between the ROM read
// pipeline and the conv1 PE array. Simultaneous push and pop both take effect,
// including when full.
module w1_skid_fifo
   import lenet_pkg::*;
#(
   parameter int WIDTH = W1_DATA_W + W1_ADDR_W,
   parameter int DEPTH = W1_FIFO_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1),
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end

      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointer and count registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; contents are ignored while empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign valid    = (count_q != '0);
   assign count    = count_q;

endmodule

// File: rtl/w1_loader.sv
// Streams the conv1 kernel taps from the external weight ROM to the PE array.
// Reads are issued only when a FIFO slot is guaranteed, so back-pressure from
// the PE array never reaches the ROM address combinationally.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   LD_IDLE  | waiting for load_start, ROM address parked at 0
//   LD_FETCH | issuing one ROM read per cycle while FIFO room allows
//   LD_DRAIN | all reads issued, waiting for remaining taps to be taken
//   LD_DONE  | one-cycle load_done pulse, load_start ignored
module w1_loader
   import lenet_pkg::*;
#(
   parameter int NUM_TAPS = W1_TAPS,
   parameter int DATA_W   = W1_DATA_W,
   parameter int ADDR_W   = W1_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   output logic [ADDR_W-1:0] w1_raddr,
   input  logic [DATA_W-1:0] w1_rdata,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] w_tap,
   output logic              load_busy,
   output logic              load_done
);

   localparam int                FIFO_W   = DATA_W + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

   w1_ld_state_e      state_q, state_d;
   logic [ADDR_W-1:0] tap_cnt_q, tap_cnt_d;
   logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W-1:0] itap_q, itap_d;
   logic              inflight_q, inflight_d;

   logic              issue;
   logic              pop;
   logic [1:0]        fifo_count;
   logic              fifo_valid;
   logic [FIFO_W-1:0] fifo_head;

   // Read issue decision depends only on registered state and occupancy.
   always_comb begin
      issue = (state_q == LD_FETCH) && w1_has_room(fifo_count, inflight_q);
   end

   // Sequencer, tap/accept counters and read pipeline next-state.
   always_comb begin
      state_d    = state_q;
      tap_cnt_d  = tap_cnt_q;
      acc_cnt_d  = acc_cnt_q;
      raddr_d    = raddr_q;
      inflight_d = issue;
      itap_d     = issue ? tap_cnt_q : itap_q;

      if (pop) begin
         acc_cnt_d = acc_cnt_q + ADDR_W'(1);
      end

      case (state_q)
         LD_IDLE: begin
            raddr_d   = '0;
            acc_cnt_d = '0;
            if (load_start) begin
               state_d   = LD_FETCH;
               tap_cnt_d = '0;
            end
         end
         LD_FETCH: begin
            if (issue) begin
               raddr_d   = tap_cnt_q;
               tap_cnt_d = tap_cnt_q + ADDR_W'(1);
               if (tap_cnt_q == LAST_TAP) begin
                  state_d = LD_DRAIN;
               end
            end
         end
         LD_DRAIN: begin
            if (pop && (acc_cnt_q == LAST_TAP)) begin
               state_d = LD_DONE;
            end
         end
         LD_DONE: begin
            state_d   = LD_IDLE;
            raddr_d   = '0;
            tap_cnt_d = '0;
         end
         default: begin
            state_d = LD_IDLE;
         end
      endcase
   end

   // State registers; reset drops any read still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LD_IDLE;
         tap_cnt_q  <= '0;
         acc_cnt_q  <= '0;
         raddr_q    <= '0;
         itap_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_cnt_q  <= tap_cnt_d;
         acc_cnt_q  <= acc_cnt_d;
         raddr_q    <= raddr_d;
         itap_q     <= itap_d;
         inflight_q <= inflight_d;
      end
   end

   assign pop = fifo_valid && w_ready;

   w1_skid_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (W1_FIFO_DEPTH),
      .CNT_W (2)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({w1_rdata, itap_q}),
      .pop       (pop),
      .pop_data  (fifo_head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   // The address being read this cycle is shown directly; otherwise the last one is held.
   assign w1_raddr  = issue ? tap_cnt_q : raddr_q;
   assign w_valid   = fifo_valid;
   assign w_data    = fifo_head[FIFO_W-1:ADDR_W];
   assign w_tap     = fifo_head[ADDR_W-1:0];
   assign load_busy = (state_q != LD_IDLE);
   assign load_done = (state_q == LD_DONE);

endmodule

// File: tb/tb_w1_loader.sv
// Scoreboard bench for w1_loader: the stimulus pushes expected tap indices
// when a load is started, a negedge monitor pops and compares on each transfer.
module tb_w1_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [4:0]  w1_raddr;
   logic [47:0] w1_rdata;
   logic        w_valid;
   logic        w_ready;
   logic [47:0] w_data;
   logic [4:0]  w_tap;
   logic        load_busy;
   logic        load_done;

   int          n_tests  = 0;
   int          n_fail   = 0;
   int          xfer_cnt = 0;
   int          sb[$];

   logic [47:0] rom_q = '0;

   logic        hold_v    = 1'b0;
   logic [4:0]  hold_tap  = '0;
   logic [47:0] hold_data = '0;

   always #5 clk = ~clk;

   w1_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .w1_raddr   (w1_raddr),
      .w1_rdata   (w1_rdata),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .w_tap      (w_tap),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   function automatic logic [47:0] exp_word(input logic [4:0] a);
      logic [47:0] w;
      for (int i = 0; i < 6; i++) w[i*8 +: 8] = {3'b000, a};
      return w;
   endfunction

   // Registered ROM model: data one cycle after the address.
   always @(posedge clk) rom_q <= exp_word(w1_raddr);
   assign w1_rdata = rom_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: in-order delivery against the scoreboard, plus hold stability.
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", w_valid, 1'b1);
            check("hold_tap", w_tap, hold_tap);
            check("hold_data", w_data, hold_data);
         end
         hold_v    = w_valid && !w_ready;
         hold_tap  = w_tap;
         hold_data = w_data;
         if (w_valid && w_ready) begin
            xfer_cnt++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_xfer: got tap %0d expected no transfer at %0t", w_tap, $time);
            end else begin
               int t;
               t = sb.pop_front();
               n_tests--;
               check("xfer_tap", w_tap, t);
               check("xfer_data", w_data, exp_word(5'(t)));
            end
         end
      end
   end

   task automatic push_expected();
      xfer_cnt = 0;
      for (int t = 0; t < 25; t++) sb.push_back(t);
   endtask

   // Pulse load_start for the cycle after the next edge (cycle 0); returns in cycle 1.
   task automatic start_run();
      @(posedge clk); #1;
      load_start = 1'b1;
      push_expected();
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic wait_done(input int max, input bit alt);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (load_done) begin
            seen = 1'b1;
            break;
         end
         if (alt) begin
            @(posedge clk); #1;
            w_ready = !w_ready;
         end
      end
      check("done_seen", seen, 1'b1);
   endtask

   task automatic end_run_check(input string tag);
      check({tag, "_xfer_count"}, xfer_cnt, 25);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      w_ready    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", w_valid, 1'b0);
      check("rst_busy", load_busy, 1'b0);
      check("rst_done", load_done, 1'b0);
      check("rst_raddr", w1_raddr, 0);

      // Full-rate stream with exact cycle timing.
      w_ready = 1'b1;
      start_run();
      for (int c = 1; c <= 29; c++) begin
         @(negedge clk);
         if (c <= 25) check($sformatf("t1_raddr_c%0d", c), w1_raddr, c - 1);
         check($sformatf("t1_valid_c%0d", c), w_valid, (c >= 3 && c <= 27));
         check($sformatf("t1_done_c%0d", c), load_done, (c == 28));
         check($sformatf("t1_busy_c%0d", c), load_busy, (c <= 28));
      end
      end_run_check("t1");

      // Stalled consumer for 10 cycles.
      w_ready = 1'b0;
      start_run();
      repeat (10) @(negedge clk);
      check("t2_raddr_stall", w1_raddr, 2);
      check("t2_valid_stall", w_valid, 1'b1);
      check("t2_tap_stall", w_tap, 0);
      check("t2_data_stall", w_data, exp_word(5'd0));
      check("t2_busy_stall", load_busy, 1'b1);
      @(posedge clk); #1;
      w_ready = 1'b1;
      wait_done(100, 1'b0);
      end_run_check("t2");
      @(negedge clk);

      // Alternating ready.
      w_ready = 1'b1;
      start_run();
      wait_done(200, 1'b1);
      end_run_check("t3");
      @(posedge clk); #1;
      w_ready = 1'b1;

      // load_start during FETCH and DONE is ignored; next IDLE starts a clean run.
      start_run();
      repeat (3) @(posedge clk);
      #1 load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      wait_done(100, 1'b0);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      check("t4_idle_busy", load_busy, 1'b0);
      check("t4_idle_done", load_done, 1'b0);
      end_run_check("t4a");
      load_start = 1'b1;
      push_expected();
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      check("t4_restart_busy", load_busy, 1'b1);
      wait_done(100, 1'b0);
      end_run_check("t4b");
      repeat (4) @(negedge clk);
      check("t4_no_extra", xfer_cnt, 25);

      // Reset in the cycle the ROM address is 10.
      start_run();
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w1_raddr == 5'd10) begin
               found = 1'b1;
               break;
            end
         end
         check("t5_raddr10_seen", found, 1'b1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      xfer_cnt = 0;
      @(negedge clk);
      check("t5_rst_valid", w_valid, 1'b0);
      check("t5_rst_busy", load_busy, 1'b0);
      check("t5_rst_done", load_done, 1'b0);
      check("t5_rst_raddr", w1_raddr, 0);
      repeat (6) @(negedge clk);
      check("t5_quiet_xfer", xfer_cnt, 0);
      check("t5_quiet_raddr", w1_raddr, 0);
      check("t5_quiet_busy", load_busy, 1'b0);
      start_run();
      wait_done(100, 1'b0);
      end_run_check("t5");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
